// File: rtl/btn_debounce_edge.sv
// Per-channel push-button conditioner: input synchronizer, stability-counter debounce,
// press/release strobes and sticky press-pending / overflow flags.
module btn_debounce_edge #(
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] press_pending,
  output logic [NUM_BTN-1:0] overflow,
  input  logic [NUM_BTN-1:0] pending_clr
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
    $error("btn_debounce_edge: DEBOUNCE_CYCLES must be at least 1");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("btn_debounce_edge: SYNC_STAGES must be in 2..4");
  end

  localparam int unsigned CntW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] sync_q [SYNC_STAGES];
  logic [NUM_BTN-1:0] synced;
  logic [CntW-1:0]    cnt_q  [NUM_BTN];
  logic [CntW-1:0]    cnt_d  [NUM_BTN];
  logic [NUM_BTN-1:0] accept;
  logic [NUM_BTN-1:0] stable_q, stable_d;
  logic [NUM_BTN-1:0] press_q, press_d;
  logic [NUM_BTN-1:0] release_q, release_d;
  logic [NUM_BTN-1:0] pending_q, pending_d;
  logic [NUM_BTN-1:0] ovf_q, ovf_d;

  // Internally "pressed" is always 1.
  assign raw    = BTN_ACTIVE_LOW ? ~btn_in : btn_in;
  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    accept = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (synced[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntLast) begin
        cnt_d[i]  = '0;
        accept[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
  end

  always_comb begin
    stable_d  = stable_q ^ accept;
    press_d   = accept & synced;
    release_d = accept & ~synced;
    // A press always sets pending; a clear without a press drops it.
    pending_d = press_q | (pending_q & ~pending_clr);
    // Overflow needs a press onto an already-pending flag; any clear wipes it.
    ovf_d     = ~pending_clr & (ovf_q | (press_q & pending_q));
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
      stable_q  <= '0;
      press_q   <= '0;
      release_q <= '0;
      pending_q <= '0;
      ovf_q     <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= cnt_d[i];
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  assign btn_level     = stable_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign press_pending = pending_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_btn_debounce_edge.sv
// Directed bench for btn_debounce_edge with DEBOUNCE_CYCLES = 8, SYNC_STAGES = 2, NUM_BTN = 4.
module tb_btn_debounce_edge;

  logic       ACLK = 1'b0;
  logic       ARESETN;
  logic [3:0] btn_in;
  logic [3:0] btn_level, press_pulse, release_pulse, press_pending, overflow;
  logic [3:0] pending_clr;

  int n_vec = 0;
  int n_err = 0;
  int press_cnt [4];
  int release_cnt [4];

  btn_debounce_edge #(
    .NUM_BTN        (4),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(8),
    .BTN_ACTIVE_LOW (1'b0)
  ) dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .press_pending(press_pending),
    .overflow     (overflow),
    .pending_clr  (pending_clr)
  );

  always #5 ACLK = ~ACLK;

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge ACLK);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (press_pulse[i])   press_cnt[i]++;
        if (release_pulse[i]) release_cnt[i]++;
      end
    end
  endtask

  task automatic clr_counts();
    for (int i = 0; i < 4; i++) begin
      press_cnt[i]   = 0;
      release_cnt[i] = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                          input logic [3:0] rel, input logic [3:0] pnd, input logic [3:0] ovf);
    chk({tag, ".level"},   {28'd0, btn_level},     {28'd0, lvl});
    chk({tag, ".press"},   {28'd0, press_pulse},   {28'd0, prs});
    chk({tag, ".release"}, {28'd0, release_pulse}, {28'd0, rel});
    chk({tag, ".pending"}, {28'd0, press_pending}, {28'd0, pnd});
    chk({tag, ".ovf"},     {28'd0, overflow},      {28'd0, ovf});
  endtask

  initial begin
    clr_counts();
    ARESETN     = 1'b0;
    btn_in      = 4'hF;
    pending_clr = 4'h0;

    // 1. Reset with all buttons held, then release.
    step(5);
    chk_outs("rst", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    ARESETN = 1'b1;
    step(9);
    chk_outs("rel9", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    step();
    chk_outs("rel10", 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
    step();
    chk_outs("rel11", 4'hF, 4'h0, 4'h0, 4'hF, 4'h0);
    pending_clr = 4'hF;
    step();
    pending_clr = 4'h0;
    chk_outs("clr_all", 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
    btn_in = 4'h0;
    step(9);
    chk("drop9.level", {28'd0, btn_level}, 32'hF);
    step();
    chk_outs("drop10", 4'h0, 4'h0, 4'hF, 4'h0, 4'h0);
    step(3);

    // 2. Clean press and release on button 0.
    clr_counts();
    btn_in = 4'h1;
    step(9);
    chk("p0_t9.level", {28'd0, btn_level}, 32'h0);
    step();
    chk_outs("p0_t10", 4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
    step();
    chk_outs("p0_t11", 4'h1, 4'h0, 4'h0, 4'h1, 4'h0);
    step(29);
    btn_in = 4'h0;
    step(9);
    chk("r0_t49.release", {28'd0, release_pulse}, 32'h0);
    step();
    chk_outs("r0_t50", 4'h0, 4'h0, 4'h1, 4'h1, 4'h0);
    step();
    chk("r0_t51.release", {28'd0, release_pulse}, 32'h0);
    chk("p0_count", press_cnt[0], 32'd1);
    pending_clr = 4'h1;
    step();
    pending_clr = 4'h0;
    chk("p0_clr.pending", {28'd0, press_pending}, 32'h0);

    // 3. Bounce on button 1: toggle every 3 cycles for 30 cycles, then hold high.
    clr_counts();
    for (int k = 0; k < 10; k++) begin
      btn_in[1] = (k % 2 == 0);
      step(3);
    end
    btn_in[1] = 1'b1;
    step(9);
    chk("b1_t9.level", {31'd0, btn_level[1]}, 32'h0);
    step();
    chk("b1_t10.press", {28'd0, press_pulse}, 32'h2);
    step(2);
    chk("b1_press_count", press_cnt[1], 32'd1);
    chk("b1_release_count", release_cnt[1], 32'd0);
    btn_in[1] = 1'b0;
    step(12);
    chk("b1_drop.level", {28'd0, btn_level}, 32'h0);

    // 4. Glitch widths on button 2: 7 cycles rejected, 8 cycles accepted.
    clr_counts();
    btn_in[2] = 1'b1;
    step(7);
    btn_in[2] = 1'b0;
    step(20);
    chk("g7.press_count", press_cnt[2], 32'd0);
    chk("g7.level", {28'd0, btn_level}, 32'h0);
    btn_in[2] = 1'b1;
    step(8);
    btn_in[2] = 1'b0;
    step(2);
    chk("g8.press", {28'd0, press_pulse}, 32'h4);
    step(7);
    chk("g8_r7.release", {28'd0, release_pulse}, 32'h0);
    step();
    chk("g8_r8.release", {28'd0, release_pulse}, 32'h4);
    step(3);
    chk("g8.press_count", press_cnt[2], 32'd1);
    chk("g8.release_count", release_cnt[2], 32'd1);

    // 5. Sticky flags on button 3.
    pending_clr = 4'hF;
    step();
    pending_clr = 4'h0;
    chk_outs("f_clean", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    btn_in[3] = 1'b1;
    step(10);
    chk("f_p1.press", {28'd0, press_pulse}, 32'h8);
    pending_clr = 4'h8;
    step();
    pending_clr = 4'h0;
    chk_outs("f_setwins", 4'h8, 4'h0, 4'h0, 4'h8, 4'h0);
    btn_in[3] = 1'b0;
    step(12);
    btn_in[3] = 1'b1;
    step(10);
    chk("f_p2.press", {28'd0, press_pulse}, 32'h8);
    step();
    chk_outs("f_ovf", 4'h8, 4'h0, 4'h0, 4'h8, 4'h8);
    step(3);
    chk("f_ovf_hold", {28'd0, overflow}, 32'h8);
    pending_clr = 4'h8;
    step();
    pending_clr = 4'h0;
    chk_outs("f_cleared", 4'h8, 4'h0, 4'h0, 4'h0, 4'h0);

    // 6. Reset mid-debounce on button 0 (button 3 released concurrently).
    clr_counts();
    btn_in = 4'h1;
    step(7);
    ARESETN = 1'b0;
    step();
    ARESETN = 1'b1;
    chk_outs("mid_rst", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    step(9);
    chk("mid_t9.level", {28'd0, btn_level}, 32'h0);
    chk("mid_t9.press_count", press_cnt[0], 32'd0);
    step();
    chk_outs("mid_t10", 4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
    step();
    chk_outs("mid_t11", 4'h1, 4'h0, 4'h0, 4'h1, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/btn_debounce_edge.md
Name: btn_debounce_edge

Overview:
- Upstream conditioning stage for the external button counter AXI4-Lite peripheral.
- Takes raw asynchronous push-button inputs and synchronizes each one to ACLK.
- Debounces each channel with a per-channel stability counter and produces a clean level plus one-cycle press and release pulses.
- Holds sticky press-pending and overflow flags that the counter/register side consumes and clears.

Parameters:
- NUM_BTN, 4, number of independent button channels.
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer; legal range 2..4.
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized samples required to accept a level change (10 ms at 100 MHz); minimum 1, elaboration error if less.
- BTN_ACTIVE_LOW, 0, when 1, btn_in is inverted before synchronization so that "pressed" is internally 1.

Ports:
- ACLK  in  1  single system clock, rising edge.
- ARESETN  in  1  reset, synchronous, active-low.
- btn_in  in  NUM_BTN  raw asynchronous button pins.
- btn_level  out  NUM_BTN  debounced pressed level, 1 = pressed.
- press_pulse  out  NUM_BTN  one-cycle strobe on an accepted 0->1 of btn_level.
- release_pulse  out  NUM_BTN  one-cycle strobe on an accepted 1->0 of btn_level.
- press_pending  out  NUM_BTN  sticky flag, set by press_pulse.
- overflow  out  NUM_BTN  sticky flag, set by a press while press_pending is already 1.
- pending_clr  in  NUM_BTN  per-channel clear strobe for press_pending and overflow, sampled every cycle.

Behaviour:
- Interface: one clock, ACLK. Reset ARESETN is synchronous and active-low; it is sampled only on the ACLK rising edge.

Reset (ARESETN = 0 at a rising edge):
- Synchronizer stages load the inactive value (0 after optional inversion).
- Stable levels and counters clear to 0.
- All outputs are 0 on the following cycle.
- Reset asserted mid-debounce discards the count. After release, a held-pressed input needs the full SYNC_STAGES + DEBOUNCE_CYCLES again.

Per channel:
- Pipeline: raw -> optional invert -> SYNC_STAGES flops -> synced bit s.
- Stability counter width is clog2(DEBOUNCE_CYCLES+1).
  - If s == stable: counter <= 0.
  - If s != stable and counter < DEBOUNCE_CYCLES-1: counter <= counter + 1.
  - If s != stable and counter == DEBOUNCE_CYCLES-1: stable <= s and counter <= 0.
  - Net effect: a level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples. Any single matching sample restarts the count.
- btn_level = stable, registered.
- Latency from a btn_in edge to a btn_level change is SYNC_STAGES + DEBOUNCE_CYCLES cycles, with no bounce.
- press_pulse and release_pulse are registered. They are high in exactly the cycle btn_level first shows the new value. They are never both high in the same cycle. Minimum spacing between them is DEBOUNCE_CYCLES cycles.

Sticky flags (update on the next edge):
- press_pulse = 1 and pending_clr = 1:
  - press_pending <= 1 (set wins).
  - overflow <= 0.
- press_pulse = 1, pending_clr = 0, press_pending = 1: overflow <= 1.
- press_pulse = 1, pending_clr = 0, press_pending = 0: press_pending <= 1.
- press_pulse = 0 and pending_clr = 1: press_pending <= 0 and overflow <= 0.
- Otherwise both flags hold.

General rules:
- Channels are fully independent; simultaneous events on different channels are all honoured in the same cycle.
- Counter saturates by construction; there is no wrap-around.
- With DEBOUNCE_CYCLES = 1, a change is accepted on the first differing sample.

Test Plan:
All scenarios use DEBOUNCE_CYCLES = 8, SYNC_STAGES = 2, NUM_BTN = 4, BTN_ACTIVE_LOW = 0.
1. Reset: hold ARESETN = 0 for 5 cycles with btn_in = 4'hF -> every output is 0. Release reset -> btn_level = 4'hF after exactly 10 cycles, with press_pulse = 4'hF for one cycle.
2. Clean press: btn_in[0] goes 0->1 at cycle T and is held -> btn_level[0] = 1 and press_pulse[0] = 1 at cycle T+10 only, press_pending[0] = 1 from T+11. Drop to 0 at T+40 -> release_pulse[0] for one cycle at T+50.
3. Bounce: btn_in[1] toggles every 3 cycles for 30 cycles, then holds at 1 -> exactly one press_pulse[1], 10 cycles after the final edge. No release_pulse.
4. Glitch width: a 7-cycle high pulse on btn_in[2] -> no change on any output. An 8-cycle pulse -> one press_pulse[2], then one release_pulse[2] 8 cycles later.
5. Flags on btn 3: pending_clr[3] = 1 in the press_pulse[3] cycle -> press_pending[3] stays 1 and overflow[3] = 0. A second press with no clear -> overflow[3] = 1. pending_clr[3] pulse -> press_pending[3] = 0 and overflow[3] = 0 on the next cycle.
6. Reset mid-operation: assert ARESETN = 0 for 1 cycle after 5 stable pressed samples on btn_in[0] -> no press_pulse. The press is accepted 10 cycles after reset release.
